gpc_sum_accum: RTL and testbench
================================

Name: gpc_sum_accum

Overview:
- Downstream consumer of a row of gpc15_3 compressors. Each gpc15_3 produces one 3-bit count (0..7) per beat.
- Each beat, the block takes NUM_GPC such counts, reduces them to one beat sum, and accumulates beat sums over a frame delimited by in_last.
- It emits one saturating frame total per frame, over a valid/ready handshake.
- Position: final carry-propagate and accumulate stage behind the GPC compressor layer.

Parameters:
- NUM_GPC, 8, number of 3-bit GPC results per beat (>=2).
- ACC_W, 16, width of accumulator and out_sum (>= BEAT_W).
- BEAT_W, derived = clog2(7*NUM_GPC+1) (6 at default), width of one beat sum; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid&&in_ready at rising edge
- in_data  in  3*NUM_GPC  GPC result i in bits [3i+2:3i], unsigned
- in_last  in  1  final beat of frame
- out_valid  out  1  frame total present
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_sum  out  ACC_W  saturated frame total
- out_overflow  out  1  frame total saturated

Behaviour:
- Reset (async, rst_n=0): all pipeline regs, accumulator, out_valid, out_sum, out_overflow = 0; s1_valid=0. in_ready is combinational and equals 1 while out_valid=0.
- Global enable en = !out_valid || out_ready. in_ready = en. Whole pipeline holds when en=0.
- Stage S1, at edge when en:
  - s1_valid <= in_valid.
  - If in_valid: s1_sum <= sum of all NUM_GPC fields (BEAT_W bits, exact, no truncation); s1_last <= in_last.
  - A bubble (in_valid=0) sets s1_valid=0 and leaves the accumulator untouched.
- Stage S2, at edge when en && s1_valid:
  - t = acc + s1_sum, computed ACC_W+1 wide.
  - sat = t > 2^ACC_W-1 or acc_ovf; r = sat ? 2^ACC_W-1 : t[ACC_W-1:0].
  - s1_last=0: acc <= r; acc_ovf <= sat; out_valid unchanged (it is 0 or being consumed this edge).
  - s1_last=1: out_sum <= r; out_overflow <= sat; out_valid <= 1; acc <= 0; acc_ovf <= 0 (next frame starts clean).
- out_valid clears at edge when out_ready=1, unless a new last beat completes the same edge; in that case it stays 1 with new data, giving back-to-back frames.
- Latency: a last beat accepted at edge k gives out_valid=1 after edge k+1. Throughput is 1 beat/cycle with out_ready held high.
- out_sum and out_overflow stay stable while out_valid && !out_ready.
- Single-beat frame (in_last on first beat): out_sum = beat sum.
- Once saturated, the accumulator stays at max for the rest of the frame; out_overflow reports it.
- Input fields are 3-bit; values 0..7 are all legal, so no range check.
- in_data and in_last are ignored when in_valid=0.
- Reset mid-frame discards the partial accumulation and any pending output; no output for that frame.

Decomposition:
- Package gpc_pkg:
  - GPC_OUT_W = 3 and GPC_MAX = 7 (shared with the gpc15_3 generator output).
  - Function clog2 used to derive BEAT_W.
- Sub-module gpc_row_adder (combinational, NUM_GPC x 3-bit to BEAT_W sum).
  - Balanced adder tree.
  - Kept separate so the generator can later swap in a GPC-based reduction.
- gpc_sum_accum holds handshake, S1/S2 regs and saturation only.

Test Plan:
- Reset/idle: rst_n=0 then 1, no input -> out_valid=0, out_sum=0, out_overflow=0, in_ready=1.
- Single beat: all fields=7, in_last=1, out_ready=1 -> one cycle later out_sum=56, out_overflow=0, out_valid pulses for exactly 1 cycle.
- Multi-beat with bubbles: beats with field patterns summing to 10, 0, 25 (in_last on third), idle cycles between -> out_sum=35, then the next single-beat frame summing to 3 gives out_sum=3 (accumulator cleared).
- Backpressure: out_ready=0 while two frames (sums 12 then 20) are offered -> first out_sum=12 held stable, in_ready=0 after S2 fills; on out_ready=1, 12 then 20 delivered in consecutive cycles with no loss.
- Saturation (ACC_W=8): 5 beats of 56 with in_last on fifth -> out_sum=255, out_overflow=1; the following frame of one beat summing to 4 -> out_sum=4, out_overflow=0.
- Async reset mid-frame: two non-last beats (sum 30), rst_n low for half a cycle, then single-beat frame summing to 5 -> out_sum=5 (partial frame discarded), outputs were 0 during reset.

Source files
------------

// File: rtl/gpc_pkg.sv
// Shared constants for the GPC compressor layer and its downstream adders.
package gpc_pkg;

  localparam int GPC_OUT_W = 3;
  localparam int GPC_MAX   = 7;

  // Ceiling log2, constant-foldable for parameter derivation.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpc_row_adder.sv
// Combinational reduction of NUM_GPC 3-bit GPC counts into one exact beat sum.
module gpc_row_adder
  import gpc_pkg::*;
#(
  parameter int NUM_GPC = 8,
  parameter int BEAT_W  = 6
) (
  input  logic [GPC_OUT_W*NUM_GPC-1:0] in_data,
  output logic [BEAT_W-1:0]            sum
);

  localparam int LEVELS = clog2(NUM_GPC);
  localparam int PAD    = 1 << LEVELS;

  logic [BEAT_W-1:0] node [PAD];

  // Leaves padded to a power of two, then summed pairwise in place level by level.
  always_comb begin
    for (int i = 0; i < PAD; i++) node[i] = '0;
    for (int i = 0; i < NUM_GPC; i++) begin
      node[i] = BEAT_W'(in_data[GPC_OUT_W*i +: GPC_OUT_W]);
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < (PAD >> (lvl + 1)); i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    sum = node[0];
  end

endmodule

// File: rtl/gpc_sum_accum.sv
// Accumulates per-beat GPC count sums over a frame and emits a saturating frame total.
module gpc_sum_accum
  import gpc_pkg::*;
#(
  parameter int NUM_GPC = 8,
  parameter int ACC_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [GPC_OUT_W*NUM_GPC-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic                         out_overflow
);

  localparam int BEAT_W = clog2(GPC_MAX*NUM_GPC + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [BEAT_W-1:0] s1_sum_q, s1_sum_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic              out_overflow_q, out_overflow_d;

  logic [BEAT_W-1:0] beat_sum;
  logic              en;
  logic [ACC_W:0]    t;
  logic              sat;
  logic [ACC_W-1:0]  r;

  gpc_row_adder #(.NUM_GPC(NUM_GPC), .BEAT_W(BEAT_W)) u_row_adder (
    .in_data (in_data),
    .sum     (beat_sum)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready; the whole
  // pipeline advances only when the output slot is empty or being drained (en), so
  // in_ready is simply en and nothing moves while the consumer stalls.
  always_comb begin
    en  = !out_valid_q || out_ready;
    t   = {1'b0, acc_q} + (ACC_W+1)'(s1_sum_q);
    sat = t[ACC_W] || acc_ovf_q;
    r   = sat ? ACC_MAX : t[ACC_W-1:0];

    s1_valid_d     = s1_valid_q;
    s1_last_d      = s1_last_q;
    s1_sum_d       = s1_sum_q;
    acc_d          = acc_q;
    acc_ovf_d      = acc_ovf_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_overflow_d = out_overflow_q;

    if (en) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q && s1_last_q;
      if (in_valid) begin
        s1_sum_d  = beat_sum;
        s1_last_d = in_last;
      end
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_sum_d      = r;
          out_overflow_d = sat;
          acc_d          = '0;
          acc_ovf_d      = 1'b0;
        end else begin
          acc_d     = r;
          acc_ovf_d = sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_sum_q       <= '0;
      acc_q          <= '0;
      acc_ovf_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_last_q      <= s1_last_d;
      s1_sum_q       <= s1_sum_d;
      acc_q          <= acc_d;
      acc_ovf_q      <= acc_ovf_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign in_ready     = en;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_gpc_sum_accum.sv
// Self-checking bench for gpc_sum_accum with a saturating frame-total reference model.
module tb_gpc_sum_accum;

  localparam int NUM_GPC = 8;
  localparam int ACC_W   = 8;
  localparam int DW      = 3 * NUM_GPC;
  localparam int ACC_MAXV = (1 << ACC_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;

  logic [ACC_W:0] exp_q[$];
  int checks;
  int failures;
  int delivered;
  int m_acc;
  bit m_ovf;
  bit rand_ready;

  gpc_sum_accum #(.NUM_GPC(NUM_GPC), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int field_sum(input logic [DW-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < NUM_GPC; i++) s += int'(d[3*i +: 3]);
    return s;
  endfunction

  // Random field split that adds up to the requested beat sum.
  function automatic logic [DW-1:0] make_data(input int s);
    logic [DW-1:0] d;
    int rem;
    int lo;
    int hi;
    int f;
    d = '0;
    rem = s;
    for (int i = 0; i < NUM_GPC; i++) begin
      lo = rem - 7 * (NUM_GPC - 1 - i);
      if (lo < 0) lo = 0;
      hi = (rem < 7) ? rem : 7;
      f = int'($urandom_range(hi, lo));
      d[3*i +: 3] = 3'(f);
      rem -= f;
    end
    return d;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    int t;
    bit sat;
    int r;
    t = m_acc + field_sum(d);
    sat = (t > ACC_MAXV) || m_ovf;
    r = sat ? ACC_MAXV : t;
    if (last) begin
      exp_q.push_back({sat, r[ACC_W-1:0]});
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      m_acc = r;
      m_ovf = sat;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int cyc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    cyc = 0;
    while (!in_ready && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else model_accept(d, last);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom());
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    #3;
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: compare each delivered total against the model queue.
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_sum", out_sum, e[ACC_W-1:0]);
        check("out_overflow", out_overflow, e[ACC_W]);
        delivered++;
      end
    end
  end

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int d0;
    checks = 0; failures = 0; delivered = 0;
    m_acc = 0; m_ovf = 1'b0; rand_ready = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // Reset and idle
    idle(3);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(3);
    #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    @(negedge clk);

    // Single-beat frame, all fields at max
    send_beat({NUM_GPC{3'd7}}, 1'b1);
    #1;
    check("lat_not_yet", out_valid, 0);
    @(negedge clk);
    #1;
    check("single_valid", out_valid, 1);
    check("single_sum", out_sum, 56);
    @(negedge clk);
    #1;
    check("single_pulse_end", out_valid, 0);
    @(negedge clk);

    // Multi-beat frame with bubbles, then a frame proving the accumulator cleared
    send_beat(make_data(10), 1'b0);
    idle(2);
    send_beat(make_data(0), 1'b0);
    idle(1);
    send_beat(make_data(25), 1'b1);
    wait_drain();
    check("multi_sum", out_sum, 35);
    @(negedge clk);
    send_beat(make_data(3), 1'b1);
    wait_drain();
    check("after_clear_sum", out_sum, 3);
    idle(2);

    // Backpressure: two frames queued behind a stalled consumer
    out_ready = 1'b0;
    send_beat(make_data(12), 1'b1);
    send_beat(make_data(20), 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_hold_sum", out_sum, 12);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    d0 = delivered;
    out_ready = 1'b1;
    @(negedge clk);
    #3;
    check("bp_back_to_back", delivered - d0, 2);
    @(negedge clk);
    #1;
    check("bp_done_valid", out_valid, 0);
    @(negedge clk);

    // Saturation at ACC_W=8, then a clean frame
    for (int i = 0; i < 5; i++) send_beat({NUM_GPC{3'd7}}, (i == 4));
    wait_drain();
    check("sat_sum", out_sum, ACC_MAXV);
    check("sat_ovf", out_overflow, 1);
    @(negedge clk);
    send_beat(make_data(4), 1'b1);
    wait_drain();
    check("post_sat_sum", out_sum, 4);
    check("post_sat_ovf", out_overflow, 0);
    idle(2);

    // Asynchronous reset in the middle of a frame
    send_beat(make_data(15), 1'b0);
    send_beat(make_data(15), 1'b0);
    rst_n = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_out_overflow", out_overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(make_data(5), 1'b1);
    wait_drain();
    check("after_rst_sum", out_sum, 5);
    @(negedge clk);

    // Random traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send_beat(make_data(int'($urandom_range(0, 56))), ($urandom_range(0, 3) == 0));
    end
    send_beat(make_data(1), 1'b1);
    rand_ready = 1'b0;
    @(negedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    idle(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
